hazard_control_unit: RTL and testbench
======================================

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 Parameter BIT_WIDTH, default 5, register-address width.
REQ-002 Parameter MDU_CYCLES, default 4, number of front-end stall cycles after a mult/div issue; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 IF_ID_Rs  input  BIT_WIDTH  Rs of the instruction in ID.
REQ-006 IF_ID_Rt  input  BIT_WIDTH  Rt of the instruction in ID.
REQ-007 ID_UsesRt  input  1  the ID instruction reads Rt as a source.
REQ-008 ID_EX_Rt  input  BIT_WIDTH  destination of the instruction in EX.
REQ-009 ID_EX_MemRead  input  1  the EX instruction is a load.
REQ-010 ID_MduStart  input  1  the ID instruction is a mult/div.
REQ-011 EX_BranchTaken  input  1  the branch in EX resolved as taken.
REQ-012 PC_Write  output  1  enables the PC update.
REQ-013 IF_ID_Write  output  1  enables the IF/ID register.
REQ-014 ID_EX_Bubble  output  1  zeroes the ID/EX control fields.
REQ-015 IF_ID_Flush  output  1  clears the IF/ID register.
REQ-016 MduBusy  output  1  high in MDU_WAIT.
REQ-017 StallCount  output  16  saturating count of cycles with PC_Write=0.

Function
REQ-018 The unit SHALL define the load-use hazard (LU) as ID_EX_MemRead=1, ID_EX_Rt!=0, and (ID_EX_Rt==IF_ID_Rs or (ID_UsesRt=1 and ID_EX_Rt==IF_ID_Rt)).
REQ-019 The unit SHALL implement the FSM states RUN and MDU_WAIT, plus a 4-bit down-counter cnt.
REQ-020 In RUN with LU=1 and EX_BranchTaken=0, outputs SHALL be PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, combinationally in the same cycle.
REQ-021 In RUN with LU=0, ID_MduStart=1 and EX_BranchTaken=0, the mult/div SHALL advance with no stall that cycle, and the next state SHALL be MDU_WAIT with cnt=MDU_CYCLES-1.
REQ-022 In MDU_WAIT, outputs SHALL be PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 and MduBusy=1.
REQ-023 In MDU_WAIT, cnt SHALL decrement each cycle, and the FSM SHALL return to RUN on the edge where cnt==0, giving exactly MDU_CYCLES stall cycles.
REQ-024 EX_BranchTaken=1 SHALL override everything in any state: PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1.
REQ-025 A branch during RUN SHALL suppress both the LU stall and the MDU_WAIT entry.
REQ-026 A branch during MDU_WAIT SHALL not alter state or cnt.
REQ-027 LU and ID_MduStart together SHALL resolve as LU stall only; the mult/div retries the next cycle.
REQ-028 Register 0 SHALL never create a hazard.
REQ-029 With no hazard, outputs SHALL be PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, MduBusy=0.
REQ-030 StallCount SHALL increment on every edge where PC_Write=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-031 While rst=1, the unit SHALL hold state=RUN, cnt=0, StallCount=0, and force the outputs PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, MduBusy=0, independent of the inputs.
REQ-032 Reset asserted mid-MDU_WAIT SHALL abort the wait immediately (asynchronously).
REQ-033 After reset deasserts, the first edge SHALL evaluate from RUN.

Structure
REQ-034 The state encoding (RUN=1'b0, MDU_WAIT=1'b1) and the REG_ZERO constant SHALL live in a shared pipeline package.
REQ-035 StallCount SHALL be implemented as one sub-module, sat_counter, parameterized by width (16), with clk, rst, inc and count ports.

Verification
REQ-036 Bench case: ID_EX_MemRead=1, ID_EX_Rt=5'd1, IF_ID_Rs=5'd1 -> PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1 for one cycle; after MemRead drops, normal flow resumes and StallCount=1.
REQ-037 Bench case: ID_EX_Rt=5'd0 with MemRead=1 and IF_ID_Rs=5'd0 -> no stall.
REQ-038 Bench case: IF_ID_Rt match with ID_UsesRt=0 -> no stall.
REQ-039 Bench case: ID_MduStart=1 pulse with MDU_CYCLES=4 -> MduBusy=1 and PC_Write=0 for exactly 4 cycles starting the next cycle, then RUN, with StallCount=4.
REQ-040 Bench case: EX_BranchTaken=1 coincident with LU=1 -> IF_ID_Flush=1, ID_EX_Bubble=1, PC_Write=1; then EX_BranchTaken=1 in the 2nd MDU_WAIT cycle -> flush outputs that cycle, and MDU_WAIT still ends after 4 total cycles.
REQ-041 Bench case: rst pulse in the 2nd MDU_WAIT cycle -> MduBusy=0 and PC_Write=1 immediately, StallCount=0.
REQ-042 Bench case: force 65540 LU cycles -> StallCount holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_control_unit_pkg.sv
// Shared pipeline definitions for the hazard control unit: FSM encoding,
// the hard-wired zero register and the MDU counter reload helper.
package hazard_control_unit_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } hcu_state_e;

    localparam int REG_ZERO    = 0;
    localparam int STALL_CNT_W = 16;
    localparam int MDU_CNT_W   = 4;

    // The wait state is entered after the issue cycle, so the counter starts one short.
    function automatic logic [MDU_CNT_W-1:0] mdu_reload(input int cycles);
        return MDU_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; the pipeline is the master, the
// hazard unit the slave.
interface hazard_control_unit_if #(
    parameter int BIT_WIDTH = 5
);
    import hazard_control_unit_pkg::*;

    logic [BIT_WIDTH-1:0]   IF_ID_Rs;
    logic [BIT_WIDTH-1:0]   IF_ID_Rt;
    logic                   ID_UsesRt;
    logic [BIT_WIDTH-1:0]   ID_EX_Rt;
    logic                   ID_EX_MemRead;
    logic                   ID_MduStart;
    logic                   EX_BranchTaken;
    logic                   PC_Write;
    logic                   IF_ID_Write;
    logic                   ID_EX_Bubble;
    logic                   IF_ID_Flush;
    logic                   MduBusy;
    logic [STALL_CNT_W-1:0] StallCount;

    modport master (
        output IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_EX_Rt, ID_EX_MemRead,
               ID_MduStart, EX_BranchTaken,
        input  PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MduBusy,
               StallCount
    );

    modport slave (
        input  IF_ID_Rs, IF_ID_Rt, ID_UsesRt, ID_EX_Rt, ID_EX_MemRead,
               ID_MduStart, EX_BranchTaken,
        output PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MduBusy,
               StallCount
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Front-end hazard control: load-use stalls, fixed-latency mult/div wait,
// taken-branch flush, and a saturating stall-cycle counter.
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int BIT_WIDTH  = 5,
    parameter int MDU_CYCLES = 4
) (
    input logic                 clk,
    input logic                 rst,
    hazard_control_unit_if.slave hif
);

    hcu_state_e           state;
    hcu_state_e           state_nxt;
    logic [MDU_CNT_W-1:0] cnt;
    logic [MDU_CNT_W-1:0] cnt_nxt;
    logic                 load_use;
    logic                 stall_inc;

    always_comb begin
        load_use = hif.ID_EX_MemRead
                && (hif.ID_EX_Rt != BIT_WIDTH'(REG_ZERO))
                && ((hif.ID_EX_Rt == hif.IF_ID_Rs)
                    || (hif.ID_UsesRt && (hif.ID_EX_Rt == hif.IF_ID_Rt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        hif.PC_Write     = 1'b1;
        hif.IF_ID_Write  = 1'b1;
        hif.ID_EX_Bubble = 1'b0;
        hif.IF_ID_Flush  = 1'b0;
        hif.MduBusy      = 1'b0;

        if (!rst) begin
            hif.MduBusy = (state == MDU_WAIT);

            // A taken branch owns the outputs but leaves the MDU wait progressing.
            if (hif.EX_BranchTaken) begin
                hif.IF_ID_Flush  = 1'b1;
                hif.ID_EX_Bubble = 1'b1;
            end else if ((state == MDU_WAIT) || load_use) begin
                hif.PC_Write     = 1'b0;
                hif.IF_ID_Write  = 1'b0;
                hif.ID_EX_Bubble = 1'b1;
            end

            case (state)
                RUN: begin
                    if (!hif.EX_BranchTaken && !load_use && hif.ID_MduStart) begin
                        state_nxt = MDU_WAIT;
                        cnt_nxt   = mdu_reload(MDU_CYCLES);
                    end
                end
                MDU_WAIT: begin
                    if (cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - MDU_CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_inc = ~hif.PC_Write;
    end

    sat_counter #(
        .WIDTH(STALL_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(hif.StallCount)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int BW  = 5;
  localparam int MDU = 4;

  localparam logic [4:0] O_IDLE   = 5'b11000;
  localparam logic [4:0] O_LU     = 5'b00100;
  localparam logic [4:0] O_MDU    = 5'b00101;
  localparam logic [4:0] O_BR_RUN = 5'b11110;
  localparam logic [4:0] O_BR_MDU = 5'b11111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   m_wait = 0;    // remaining MDU wait cycles in the model, 0 means running
  int   m_stalls = 0;  // model stall counter

  hazard_control_unit_if #(.BIT_WIDTH(BW)) hif();

  hazard_control_unit #(
    .BIT_WIDTH (BW),
    .MDU_CYCLES(MDU)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  always #5 clk = ~clk;

  function automatic logic model_lu();
    return hif.ID_EX_MemRead && (hif.ID_EX_Rt != 0) &&
           ((hif.ID_EX_Rt == hif.IF_ID_Rs) ||
            (hif.ID_UsesRt && (hif.ID_EX_Rt == hif.IF_ID_Rt)));
  endfunction

  // Expected {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, MduBusy}
  function automatic logic [4:0] model_out();
    if (rst) return O_IDLE;
    if (hif.EX_BranchTaken) return (m_wait > 0) ? O_BR_MDU : O_BR_RUN;
    if (m_wait > 0) return O_MDU;
    if (model_lu()) return O_LU;
    return O_IDLE;
  endfunction

  function automatic logic [4:0] dut_out();
    return {hif.PC_Write, hif.IF_ID_Write, hif.ID_EX_Bubble, hif.IF_ID_Flush, hif.MduBusy};
  endfunction

  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses, input logic [4:0] ex_rt, input logic mr,
                       input logic ms, input logic br);
    rst                = r;
    hif.IF_ID_Rs       = rs;
    hif.IF_ID_Rt       = rt;
    hif.ID_UsesRt      = uses;
    hif.ID_EX_Rt       = ex_rt;
    hif.ID_EX_MemRead  = mr;
    hif.ID_MduStart    = ms;
    hif.EX_BranchTaken = br;
    if (r) begin
      m_wait   = 0;
      m_stalls = 0;
    end
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    logic [4:0] e;
    logic       lu;
    @(posedge clk);
    e  = model_out();
    lu = model_lu();
    if (!rst) begin
      if (!e[4] && m_stalls < 65535) m_stalls++;
      if (m_wait > 0) m_wait--;
      else if (!hif.EX_BranchTaken && !lu && hif.ID_MduStart) m_wait = MDU;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL reset_out: got %b expected %b", dut_out(), O_IDLE); end
    checks++;
    if (hif.StallCount !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", hif.StallCount); end
    tick();
    drive(1'b1, 5'd3, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL reset_hold: got %b expected %b", dut_out(), O_IDLE); end
    tick();
    idle();
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL reset_release: got %b expected %b", dut_out(), O_IDLE); end
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b0, 5'd1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_LU) begin errors++; $display("FAIL lu_stall: got %b expected %b", dut_out(), O_LU); end
    tick();
    drive(1'b0, 5'd1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL lu_resume: got %b expected %b", dut_out(), O_IDLE); end
    checks++;
    if (hif.StallCount !== 16'd1) begin errors++; $display("FAIL lu_count: got %0d expected 1", hif.StallCount); end
    tick();
  endtask

  task automatic test_reg_zero();
    drive(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL reg_zero: got %b expected %b", dut_out(), O_IDLE); end
    tick();
  endtask

  task automatic test_uses_rt();
    drive(1'b0, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL rt_unused: got %b expected %b", dut_out(), O_IDLE); end
    tick();
    drive(1'b0, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_LU) begin errors++; $display("FAIL rt_used: got %b expected %b", dut_out(), O_LU); end
    tick();
  endtask

  task automatic test_mdu();
    int s0;
    s0 = m_stalls;
    drive(1'b0, 5'd2, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL mdu_issue: got %b expected %b", dut_out(), O_IDLE); end
    tick();
    for (int i = 0; i < MDU; i++) begin
      idle();
      checks++;
      if (dut_out() !== O_MDU) begin errors++; $display("FAIL mdu_wait%0d: got %b expected %b", i, dut_out(), O_MDU); end
      tick();
    end
    idle();
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL mdu_done: got %b expected %b", dut_out(), O_IDLE); end
    checks++;
    if (hif.StallCount !== 16'(s0 + MDU)) begin errors++; $display("FAIL mdu_count: got %0d expected %0d", hif.StallCount, s0 + MDU); end
    tick();
  endtask

  task automatic test_branch();
    drive(1'b0, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b1);
    checks++;
    if (dut_out() !== O_BR_RUN) begin errors++; $display("FAIL br_lu: got %b expected %b", dut_out(), O_BR_RUN); end
    tick();
    idle();
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL br_no_mdu: got %b expected %b", dut_out(), O_IDLE); end
    tick();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < MDU; i++) begin
      drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, (i == 1));
      checks++;
      if (dut_out() !== ((i == 1) ? O_BR_MDU : O_MDU)) begin
        errors++; $display("FAIL br_mdu%0d: got %b expected %b", i, dut_out(), (i == 1) ? O_BR_MDU : O_MDU);
      end
      tick();
    end
    idle();
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL br_mdu_end: got %b expected %b", dut_out(), O_IDLE); end
    tick();
  endtask

  task automatic test_lu_and_mdu();
    drive(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== O_LU) begin errors++; $display("FAIL lumdu_stall: got %b expected %b", dut_out(), O_LU); end
    tick();
    drive(1'b0, 5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL lumdu_retry: got %b expected %b", dut_out(), O_IDLE); end
    tick();
    for (int i = 0; i < MDU; i++) begin
      idle();
      checks++;
      if (dut_out() !== O_MDU) begin errors++; $display("FAIL lumdu_wait%0d: got %b expected %b", i, dut_out(), O_MDU); end
      tick();
    end
  endtask

  task automatic test_reset_mid_wait();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    idle();
    tick();
    idle();
    checks++;
    if (dut_out() !== O_MDU) begin errors++; $display("FAIL rstmid_pre: got %b expected %b", dut_out(), O_MDU); end
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL rstmid_out: got %b expected %b", dut_out(), O_IDLE); end
    checks++;
    if (hif.StallCount !== 16'd0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", hif.StallCount); end
    tick();
    idle();
    checks++;
    if (dut_out() !== O_IDLE) begin errors++; $display("FAIL rstmid_run: got %b expected %b", dut_out(), O_IDLE); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(99) == 0),
            5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
            5'($urandom_range(3)), ($urandom_range(1) == 1),
            ($urandom_range(5) == 0), ($urandom_range(7) == 0));
      checks++;
      if (dut_out() !== model_out()) begin errors++; $display("FAIL rand_out[%0d]: got %b expected %b", i, dut_out(), model_out()); end
      checks++;
      if (hif.StallCount !== 16'(m_stalls)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, hif.StallCount, m_stalls); end
      tick();
    end
    idle();
    for (int i = 0; i < MDU + 1; i++) tick();
  endtask

  task automatic test_saturation();
    drive(1'b0, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    checks++;
    if (hif.StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt: got %0h expected ffff", hif.StallCount); end
    checks++;
    if (dut_out() !== O_LU) begin errors++; $display("FAIL sat_out: got %b expected %b", dut_out(), O_LU); end
    idle();
    tick();
    checks++;
    if (hif.StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %0h expected ffff", hif.StallCount); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_reg_zero();
    test_uses_rt();
    test_mdu();
    test_branch();
    test_lu_and_mdu();
    test_reset_mid_wait();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
